// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - MMIO map constants and byte-lane merge helper for data_mem_resp
package data_mem_pkg;

  // Upper half-word that selects the register window instead of RAM
  localparam logic [15:0] MMIO_BASE   = 16'hBFAF;

  // Register offsets inside the window (word aligned)
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SW      = 16'hF004;
  localparam logic [15:0] OFF_TIMER   = 16'hF008;
  localparam logic [15:0] OFF_SCRATCH = 16'hF00C;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_be.sv
// rtl/bram_be.sv - byte-enabled single-port RAM, synchronous read, read-before-write
module bram_be #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_rdata;

  // Enabled access: capture old word, then update strobed lanes
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int i = 0; i < 4; i++) begin
        if (i_wen[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data memory with MMIO registers; TIMER built only with DATA_MEM_TIMER_EN
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LED_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [7:0]       sw,
  output logic [31:0]      rdata,
  output logic             err,
  output logic [LED_W-1:0] led
);

  logic             w_is_mmio;
  logic [15:0]      w_off;
  logic             w_mmio_acc;
  logic             w_mmio_wr;
  logic             w_ram_en;
  logic             w_mapped;
  logic [31:0]      w_mmio_rd;
  logic [31:0]      w_led_ext;
  logic [31:0]      w_led_wr;
  logic [31:0]      w_ram_rdata;
  logic             w_unused;

  logic [LED_W-1:0] r_led;
  logic [31:0]      r_scratch;
  logic [7:0]       r_sw;
  logic [31:0]      r_mmio_rdata;
  logic             r_sel_ram;
  logic             r_err;

  // Byte-offset bits only matter for lane selection, never for decode
  assign w_unused   = ^addr;
  assign w_is_mmio  = (addr[31:16] == MMIO_BASE);
  assign w_off      = {addr[15:2], 2'b00};
  assign w_mmio_acc = en & w_is_mmio;
  assign w_mmio_wr  = w_mmio_acc & (|wen);
  assign w_ram_en   = en & rst & ~w_is_mmio;

  // Zero-extend LED so it can share the 32-bit lane merge and read path
  always_comb begin
    w_led_ext              = '0;
    w_led_ext[LED_W-1:0]   = r_led;
  end

  assign w_led_wr = lane_merge(w_led_ext, wdata, wen);

`ifdef DATA_MEM_TIMER_EN
  logic [31:0] r_timer;

  // Free-running counter; a write wins over the increment for that cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_mmio_wr && (w_off == OFF_TIMER)) begin
      r_timer <= lane_merge(r_timer, wdata, wen);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  // Register read mux; unmapped offsets read zero and flag an error
  always_comb begin
    w_mmio_rd = '0;
    w_mapped  = 1'b1;
    case (w_off)
      OFF_LED:     w_mmio_rd = w_led_ext;
      OFF_SW:      w_mmio_rd = {24'h0, r_sw};
`ifdef DATA_MEM_TIMER_EN
      OFF_TIMER:   w_mmio_rd = r_timer;
`else
      OFF_TIMER:   w_mmio_rd = '0;
`endif
      OFF_SCRATCH: w_mmio_rd = r_scratch;
      default:     w_mapped  = 1'b0;
    endcase
  end

  // LED, SCRATCH and the switch sampler; SW itself is read-only
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led     <= '0;
      r_scratch <= '0;
      r_sw      <= '0;
    end else begin
      r_sw <= sw;
      if (w_mmio_wr && (w_off == OFF_LED)) begin
        r_led <= w_led_wr[LED_W-1:0];
      end
      if (w_mmio_wr && (w_off == OFF_SCRATCH)) begin
        r_scratch <= lane_merge(r_scratch, wdata, wen);
      end
    end
  end

  // Capture the read source on every enabled access and hold it otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel_ram    <= 1'b0;
      r_mmio_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_mmio_acc & ~w_mapped;
      if (en) begin
        r_sel_ram    <= ~w_is_mmio;
        r_mmio_rdata <= w_is_mmio ? w_mmio_rd : 32'h0;
      end
    end
  end

  bram_be #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_wen   (wen),
    .i_addr  (addr[ADDR_W+1:2]),
    .i_wdata (wdata),
    .o_rdata (w_ram_rdata)
  );

  assign rdata = r_sel_ram ? w_ram_rdata : r_mmio_rdata;
  assign err   = r_err;
  assign led   = r_led;

endmodule
